nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Multi-cycle WIDTH-bit add/subtract unit built around one shared 4-bit carry-lookahead slice.
- The slice has generate/propagate logic and a ripple-free carry-out.
- The controller accepts an operand pair over a valid/ready handshake and feeds the slice one nibble per cycle, LSB nibble first. It registers the carry between nibbles and returns the full result over a second valid/ready handshake.
- Used wherever area matters more than latency: the datapath needs one 4-bit adder instead of WIDTH/4.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 8; any other value is a configuration error, flagged by an elaboration-time check.
- CNT_W, 8, width of the internal nibble counter. Must satisfy 2^CNT_W > WIDTH/4.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  final carry. For sub: 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state, including mid-RUN):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - Carry register, counter and operand registers cleared.
  - Any partial operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge, capture into registers:
    - a_q = a
    - b_q = sub ? ~b : b
    - carry_q = cin ^ sub
    - a_msb = a[WIDTH-1]
    - b_msb = effective b[WIDTH-1]
  - Clear counter, go to RUN.
  - sum/cout/ovf keep the previous result until overwritten.
- RUN:
  - in_ready=0. in_valid is ignored and not queued.
  - Each cycle the 4-bit slice adds a_q[3:0], b_q[3:0] and carry_q. This uses internal g/p plus lookahead carries, identical to the team's 4-bit CLA equations.
  - Slice sum nibble is shifted into the top of the result register. a_q and b_q shift right by 4.
  - carry_q <= slice carry-out. Counter increments.
  - On the cycle the counter equals WIDTH/4-1, go to DONE.
  - RUN lasts exactly WIDTH/4 cycles (4 for WIDTH=16).
- Entering DONE:
  - sum = assembled result. cout = final carry_q.
  - ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
  - out_valid=1.
- DONE:
  - out_valid held and sum/cout/ovf stable until out_valid&out_ready at an edge, then IDLE.
  - out_ready already high on DONE entry: exactly one DONE cycle.
- Latency and throughput:
  - Accept edge to first out_valid cycle: WIDTH/4+1 edges.
  - Minimum 1 IDLE cycle between operations. Throughput is one op per WIDTH/4+2 cycles.
- out_ready in IDLE/RUN is ignored.
- Arithmetic:
  - Modulo 2^WIDTH.
  - sub=1 computes A + ~B + ~cin. A-B-0 with A>=B unsigned gives cout=1.
- Wrap-around: counter never exceeds WIDTH/4-1.

Test Plan:
- Add 0x1234 + 0x4321, cin=0, sub=0, out_ready=1:
  - in_ready low for 5 cycles.
  - out_valid one cycle after 4 RUN cycles, sum=0x5555, cout=0, ovf=0.
- Carry chain: 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- Nibble-boundary carry: 0x0F0F + 0x0101, cin=1 -> sum=0x1011, cout=0.
- Signed overflow:
  - 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0.
  - sub: 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Subtract with borrow: 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0. With cin=1 -> sum=0xFFFD.
- Backpressure and robustness:
  - Hold out_ready=0 for 3 cycles in DONE -> out_valid and sum constant. Release -> IDLE next edge.
  - in_valid pulsed during RUN -> ignored, result unchanged.
  - Assert rst asynchronously in RUN cycle 2 -> all outputs 0 immediately, in_ready=1. Next op completes correctly.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract unit sharing one 4-bit CLA slice.
// Ports: clk, rst, in_valid/in_ready + a,b,cin,sub in; out_valid/out_ready + sum,cout,ovf out; busy.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end
  if ((64'd1 << CNT_W) <= 64'(NIB)) begin : g_bad_cnt
    $error("nibble_serial_adder_ctrl: CNT_W too small for WIDTH/4 nibbles");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // 4-bit carry-lookahead slice
  logic [3:0]       g;
  logic [3:0]       p;
  logic [4:0]       c;
  logic [3:0]       s;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    g    = a_q[3:0] & b_q[3:0];
    p    = a_q[3:0] ^ b_q[3:0];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
    // nibbles enter at the top, so after NIB shifts the LSB nibble is at bit 0
    res_d = {s, res_q[WIDTH-1:4]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= cin ^ sub;
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1] ^ sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= c[4];
          if (cnt_q == CNT_W'(NIB - 1)) begin
            sum_q       <= res_d;
            cout_q      <= c[4];
            ovf_q       <= (a_msb_q == b_msb_q) && (s[3] != a_msb_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// One task per scenario; each does its own inline comparisons.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  // Present one operand pair, return edges from accept to out_valid.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic icin, input logic isub,
                       output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b want 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_timing();
    int low = 0;
    int lat = 0;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!in_ready && low < 20) begin
      if (out_valid && lat == 0) begin
        lat = low;
        checks++;
        if ({sum, cout, ovf} !== {16'h5555, 2'b00}) begin
          errors++;
          $display("FAIL add_basic: got sum=%h c=%b o=%b want 5555 0 0", sum, cout, ovf);
        end
      end
      low++;
      @(posedge clk); #1;
    end
    checks++;
    if (low != 5) begin
      errors++;
      $display("FAIL in_ready_low: got %0d cycles want 5", low);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency: got out_valid at sample %0d want 4", lat);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: got vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_arith();
    logic [15:0] va [7];
    logic [15:0] vb [7];
    logic        vc [7];
    logic        vs [7];
    logic [17:0] exp [7];
    int lat;
    va = '{16'hFFFF, 16'h0F0F, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005, 16'hA5A5};
    vb = '{16'h0001, 16'h0101, 16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h5A5B};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // {sum, cout, ovf}
    exp = '{{16'h0000, 2'b10}, {16'h1011, 2'b00}, {16'h8000, 2'b01},
            {16'h7FFF, 2'b11}, {16'hFFFE, 2'b00}, {16'hFFFD, 2'b00},
            {16'h0000, 2'b10}};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vc[i], vs[i], lat);
      checks++;
      if (!out_valid || {sum, cout, ovf} !== exp[i]) begin
        errors++;
        $display("FAIL arith[%0d]: got vld=%b sum=%h c=%b o=%b want 1 %h %b %b",
                 i, out_valid, sum, cout, ovf, exp[i][17:2], exp[i][1], exp[i][0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (!out_valid || sum !== 16'h3333) begin
        errors++;
        $display("FAIL hold[%0d]: got vld=%b sum=%h want 1 3333", i, out_valid, sum);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_in_valid_during_run();
    int n = 0;
    @(negedge clk);
    a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_rdy: got in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!out_valid || {sum, cout, ovf} !== {16'h0406, 2'b00}) begin
      errors++;
      $display("FAIL run_ignore: got vld=%b sum=%h c=%b o=%b want 1 0406 0 0",
               out_valid, sum, cout, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL run_queue: got busy=%b want 0 (nothing queued)", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL async_rst: got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b want 1 0 0 0000 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(16'h4000, 16'h4000, 1'b0, 1'b0, lat);
    checks++;
    if (!out_valid || {sum, cout, ovf} !== {16'h8000, 2'b01} || lat != 4) begin
      errors++;
      $display("FAIL post_rst: got vld=%b sum=%h c=%b o=%b lat=%0d want 1 8000 0 1 4",
               out_valid, sum, cout, ovf, lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_arith();
    test_backpressure();
    test_in_valid_during_run();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
